alu_op_decoder_stage: RTL and testbench

- Registered decode stage that turns RISC-V instruction fields (opcode, funct3, funct7) into the 4-bit ALU Operation code the ALU consumes.
- Sits between the instruction-decode register and the ALU/execute stage.
- Uses a valid/ready handshake on both sides with a 2-entry skid buffer, so in_ready is a registered signal.
- Flags illegal encodings and branch semantics alongside the Operation code.

---
 rtl/alu_op_decoder_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_op_decoder_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder_stage.sv
// ---------------------------------------------------------------------------
// alu_op_decoder_stage
//
// Registered decode stage between the instruction-decode register and the
// ALU/execute stage. It turns the RISC-V opcode/funct3/funct7 fields into the
// ALU Operation code plus a few side flags. Decoded entries are held in a
// 2-entry skid buffer so that in_ready can be a plain register.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset, drops all buffered entries
//   flush          synchronous flush, empties the buffer at the next edge
//   in_valid       upstream fields valid
//   in_ready       stage can accept (registered)
//   in_opcode      instruction[6:0]
//   in_funct3      instruction[14:12]
//   in_funct7      instruction[31:25]
//   out_valid      decoded entry available
//   out_ready      downstream accepts
//   out_operation  ALU Operation code
//   out_src_b_imm  ALU SrcB is the immediate
//   out_is_branch  conditional branch
//   out_br_invert  branch taken when ALU result is 0
//   out_illegal    unsupported encoding
//
// Optional feature, enabled by defining ALU_DECODE_STATS_EN:
//   stat_accepted  saturating count of accepted entries
//   stat_illegal   saturating count of accepted entries decoded as illegal
// ---------------------------------------------------------------------------
module alu_op_decoder_stage #(
  parameter int OPCODE_LENGTH  = 4,
  parameter int INSTR_OPCODE_W = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_OPCODE_W-1:0] in_opcode,
  input  logic [2:0]                in_funct3,
  input  logic [6:0]                in_funct7,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_LENGTH-1:0]  out_operation,
  output logic                      out_src_b_imm,
  output logic                      out_is_branch,
  output logic                      out_br_invert,
  output logic                      out_illegal
`ifdef ALU_DECODE_STATS_EN
  ,
  output logic [31:0]               stat_accepted,
  output logic [31:0]               stat_illegal
`endif
);

  // ALU Operation codes
  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE   = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT   = OPCODE_LENGTH'(4'b1101);

  // Instruction opcodes
  localparam logic [INSTR_OPCODE_W-1:0] OPC_RTYPE  = INSTR_OPCODE_W'(7'b0110011);
  localparam logic [INSTR_OPCODE_W-1:0] OPC_IALU   = INSTR_OPCODE_W'(7'b0010011);
  localparam logic [INSTR_OPCODE_W-1:0] OPC_LOAD   = INSTR_OPCODE_W'(7'b0000011);
  localparam logic [INSTR_OPCODE_W-1:0] OPC_STORE  = INSTR_OPCODE_W'(7'b0100011);
  localparam logic [INSTR_OPCODE_W-1:0] OPC_JALR   = INSTR_OPCODE_W'(7'b1100111);
  localparam logic [INSTR_OPCODE_W-1:0] OPC_BRANCH = INSTR_OPCODE_W'(7'b1100011);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Buffer FSM states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Stored entry layout: {illegal, br_invert, is_branch, src_b_imm, operation}
  localparam int ENTRY_W = OPCODE_LENGTH + 4;

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_imm;
  logic                     dec_br;
  logic                     dec_inv;
  logic                     dec_ill;
  logic [ENTRY_W-1:0]       dec_entry;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] tail;
  logic               push;
  logic               pop;

  // Field decode of the incoming instruction.
  always_comb begin
    dec_op  = OP_AND;
    dec_imm = 1'b0;
    dec_br  = 1'b0;
    dec_inv = 1'b0;
    dec_ill = 1'b0;
    case (in_opcode)
      OPC_RTYPE: begin
        if (in_funct7 == F7_BASE) begin
          case (in_funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (in_funct7 == F7_ALT && in_funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (in_funct7 == F7_ALT && in_funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_IALU: begin
        // funct7 only matters for the shift-immediate forms
        dec_imm = 1'b1;
        case (in_funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001: begin
            dec_op  = OP_SLL;
            dec_ill = (in_funct7 != F7_BASE);
          end
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101: begin
            if (in_funct7 == F7_BASE)     dec_op = OP_SRL;
            else if (in_funct7 == F7_ALT) dec_op = OP_SRA;
            else                          dec_ill = 1'b1;
          end
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec_op  = OP_ADD;
        dec_imm = 1'b1;
      end
      OPC_BRANCH: begin
        // BGE/BGEU reuse LT/SLTU with the taken sense inverted
        dec_br = 1'b1;
        case (in_funct3)
          3'b000: dec_op = OP_EQ;
          3'b001: dec_op = OP_NE;
          3'b100: dec_op = OP_LT;
          3'b101: begin
            dec_op  = OP_LT;
            dec_inv = 1'b1;
          end
          3'b110: dec_op = OP_SLTU;
          3'b111: begin
            dec_op  = OP_SLTU;
            dec_inv = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // An illegal entry carries nothing but the illegal flag.
    if (dec_ill) begin
      dec_op  = OP_AND;
      dec_imm = 1'b0;
      dec_br  = 1'b0;
      dec_inv = 1'b0;
    end
  end

  assign dec_entry = {dec_ill, dec_inv, dec_br, dec_imm, dec_op};

  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next buffer occupancy. A push in TWO cannot happen because in_ready
  // is already low there.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_TWO;
          else if (!push && pop) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
    end
  end

  // Entry storage: head feeds the outputs, tail is the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      case (state)
        ST_EMPTY: if (push) head <= dec_entry;
        ST_ONE: begin
          if (push && pop) head <= dec_entry;
          else if (push)   tail <= dec_entry;
        end
        ST_TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign out_operation = head[OPCODE_LENGTH-1:0];
  assign out_src_b_imm = head[OPCODE_LENGTH];
  assign out_is_branch = head[OPCODE_LENGTH+1];
  assign out_br_invert = head[OPCODE_LENGTH+2];
  assign out_illegal   = head[OPCODE_LENGTH+3];

`ifdef ALU_DECODE_STATS_EN
  // Saturating counters; a flush does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accepted <= '0;
      stat_illegal  <= '0;
    end else if (push) begin
      if (stat_accepted != 32'hFFFF_FFFF) stat_accepted <= stat_accepted + 32'd1;
      if (dec_ill && stat_illegal != 32'hFFFF_FFFF) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_decoder_stage.sv
module tb_alu_op_decoder_stage;

  typedef struct packed {
    logic       ill;
    logic       inv;
    logic       br;
    logic       imm;
    logic [3:0] op;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic [6:0] in_funct7;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_operation;
  logic       out_src_b_imm;
  logic       out_is_branch;
  logic       out_br_invert;
  logic       out_illegal;
`ifdef ALU_DECODE_STATS_EN
  logic [31:0] stat_accepted;
  logic [31:0] stat_illegal;
`endif

  int checks = 0;
  int passes = 0;

  // Reference tables indexed by funct3
  logic [3:0] alu_base [8] = '{4'h2, 4'h4, 4'h5, 4'hC, 4'h6, 4'h7, 4'h1, 4'h0};
  logic [3:0] br_base  [8] = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hD, 4'hD, 4'hC, 4'hC};

  exp_t q[$];

  alu_op_decoder_stage #(.OPCODE_LENGTH(4), .INSTR_OPCODE_W(7)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_operation(out_operation),
    .out_src_b_imm(out_src_b_imm),
    .out_is_branch(out_is_branch),
    .out_br_invert(out_br_invert),
    .out_illegal(out_illegal)
`ifdef ALU_DECODE_STATS_EN
    ,
    .stat_accepted(stat_accepted),
    .stat_illegal(stat_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode rules written directly from the instruction tables
  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    exp_t e;
    e = '0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'h00) e.op = alu_base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'h3;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'h8;
        else e.ill = 1'b1;
      end
      7'b0010011: begin
        e.imm = 1'b1;
        if (f3 == 3'd0) e.op = 4'h2;
        else if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
        else if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'h8;
        else if (f3 == 3'd5 && f7 != 7'h00) e.ill = 1'b1;
        else e.op = alu_base[f3];
      end
      7'b0000011, 7'b0100011, 7'b1100111: begin
        e.imm = 1'b1;
        e.op  = 4'h2;
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
        else begin
          e.br  = 1'b1;
          e.inv = (f3 == 3'd5 || f3 == 3'd7);
          e.op  = br_base[f3];
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g = {out_illegal, out_br_invert, out_is_branch, out_src_b_imm, out_operation};
    return g;
  endfunction

  task automatic send_one(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    send_one(7'b0110011, 3'd0, 7'h00);
    send_one(7'b0110011, 3'd4, 7'h00);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passes++;
    checks++;
    if (out_operation !== 4'h0) $display("[TB] FAIL reset_operation: got %b expected 0000", out_operation);
    else passes++;
    checks++;
    if (observed() !== 8'h00) $display("[TB] FAIL reset_flags: got %h expected 00", observed());
    else passes++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_dropped: got out_valid %b expected 0", out_valid);
    else passes++;
  endtask

  task automatic test_rtype();
    out_ready = 1'b0;
    send_one(7'b0110011, 3'd0, 7'h20);
    checks++;
    if (observed() !== 8'h03) $display("[TB] FAIL rtype_sub: got %h expected 03", observed());
    else passes++;
    drain();
    send_one(7'b0110011, 3'd5, 7'h20);
    checks++;
    if (observed() !== 8'h08) $display("[TB] FAIL rtype_sra: got %h expected 08", observed());
    else passes++;
    drain();
    send_one(7'b0110011, 3'd0, 7'h01);
    checks++;
    if (observed() !== 8'h80) $display("[TB] FAIL rtype_illegal: got %h expected 80", observed());
    else passes++;
    drain();
  endtask

  task automatic test_branch();
    out_ready = 1'b0;
    send_one(7'b1100011, 3'd5, 7'h00);
    checks++;
    if (observed() !== 8'h6D) $display("[TB] FAIL branch_bge: got %h expected 6d", observed());
    else passes++;
    drain();
    send_one(7'b1100011, 3'd7, 7'h00);
    checks++;
    if (observed() !== 8'h6C) $display("[TB] FAIL branch_bgeu: got %h expected 6c", observed());
    else passes++;
    drain();
    send_one(7'b1100011, 3'd2, 7'h00);
    checks++;
    if (observed() !== 8'h80) $display("[TB] FAIL branch_illegal: got %h expected 80", observed());
    else passes++;
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opcode = 7'b0110011; in_funct3 = 3'd0; in_funct7 = 7'h00;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_1: got %b expected 1", in_ready);
    else passes++;
    in_funct3 = 3'd4;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_after_2: got %b expected 0", in_ready);
    else passes++;
    in_funct3 = 3'd7;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_operation !== 4'h2)
      $display("[TB] FAIL bp_hold: got ready %b op %b expected ready 0 op 0010", in_ready, out_operation);
    else passes++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_operation !== 4'h6)
      $display("[TB] FAIL bp_second: got valid %b op %b expected 1 0110", out_valid, out_operation);
    else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || observed() !== 8'h00)
      $display("[TB] FAIL bp_third: got valid %b entry %h expected 1 00", out_valid, observed());
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_empty: got out_valid %b expected 0", out_valid);
    else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send_one(7'b0110011, 3'd0, 7'h00);
    send_one(7'b0110011, 3'd4, 7'h00);
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL flush_full: got in_ready %b expected 0", in_ready);
    else passes++;
    in_valid = 1'b1; in_opcode = 7'b0110011; in_funct3 = 3'd6; in_funct7 = 7'h00;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL flush_two: got valid %b ready %b expected 0 1", out_valid, in_ready);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_two_after: got out_valid %b expected 0", out_valid);
    else passes++;
    send_one(7'b0110011, 3'd0, 7'h00);
    in_valid = 1'b1; in_funct3 = 3'd6;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_push_discard: got out_valid %b expected 0", out_valid);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_push_after: got out_valid %b expected 0", out_valid);
    else passes++;
  endtask

`ifdef ALU_DECODE_STATS_EN
  task automatic test_stats();
    logic [6:0] ops [5];
    logic [2:0] f3s [5];
    ops = '{7'b0110011, 7'b1111111, 7'b0110011, 7'b1100011, 7'b0000011};
    f3s = '{3'd0, 3'd0, 3'd4, 3'd2, 3'd2};
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_opcode = ops[k]; in_funct3 = f3s[k]; in_funct7 = 7'h00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (stat_accepted !== 32'd5 || stat_illegal !== 32'd2)
      $display("[TB] FAIL stats_count: got %0d/%0d expected 5/2", stat_accepted, stat_illegal);
    else passes++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (stat_accepted !== 32'd5 || stat_illegal !== 32'd2)
      $display("[TB] FAIL stats_flush: got %0d/%0d expected 5/2", stat_accepted, stat_illegal);
    else passes++;
  endtask
`endif

  task automatic test_random();
    logic push;
    logic pop;
    int   sel;
    exp_t got;
    q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 6);
      case (sel)
        0: in_opcode = 7'b0110011;
        1: in_opcode = 7'b0010011;
        2: in_opcode = 7'b0000011;
        3: in_opcode = 7'b0100011;
        4: in_opcode = 7'b1100111;
        5: in_opcode = 7'b1100011;
        default: in_opcode = 7'($urandom);
      endcase
      in_funct3 = 3'($urandom);
      sel = $urandom_range(0, 3);
      in_funct7 = (sel == 0) ? 7'h20 : (sel == 1) ? 7'($urandom) : 7'h00;
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      checks++;
      if (out_valid !== (q.size() != 0))
        $display("[TB] FAIL rand_out_valid cycle %0d: got %b expected %b", i, out_valid, q.size() != 0);
      else passes++;
      checks++;
      if (in_ready !== (q.size() < 2))
        $display("[TB] FAIL rand_in_ready cycle %0d: got %b expected %b", i, in_ready, q.size() < 2);
      else passes++;
      if (q.size() != 0) begin
        got = observed();
        checks++;
        if (got !== q[0]) $display("[TB] FAIL rand_entry cycle %0d: got %h expected %h", i, got, q[0]);
        else passes++;
      end
      push = in_valid && (q.size() < 2);
      pop  = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ref_decode(in_opcode, in_funct3, in_funct7));
      end
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    drain();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL rand_drained: got out_valid %b expected 0", out_valid);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_opcode = 7'h00;
    in_funct3 = 3'd0;
    in_funct7 = 7'h00;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_branch();
    test_backpressure();
    test_flush();
    test_random();
`ifdef ALU_DECODE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
